// File: rtl/uart_packet_tx.sv
// Sends one packet as NUM_BYTES consecutive 8N1 UART bytes, MSB byte first and LSB bit first.
// The line is registered and idles high; done pulses once as the final stop bit ends.
module uart_packet_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_BYTES    = 5
) (
   input  logic                   clk50,
   input  logic                   rst_n,
   input  logic [8*NUM_BYTES-1:0] packet,
   input  logic                   send,
   output logic                   ready,
   output logic                   done,
   output logic                   tx_out
);

   localparam int PKT_W  = 8 * NUM_BYTES;
   localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]        state;
   logic [CNT_W-1:0]  baud_cnt;
   logic [2:0]        bit_idx;
   logic [BYTE_W-1:0] byte_idx;
   logic [7:0]        tx_byte;
   logic [PKT_W-1:0]  shift_buf;
   logic              bit_end;
   logic              load_pkt;
   logic              shift_bit;
   logic              load_byte;

   assign ready     = (state == IDLE);
   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign load_pkt  = ready && send;
   assign shift_bit = bit_end && ((state == START) || ((state == DATA) && (bit_idx != 3'd7)));
   assign load_byte = bit_end && (state == STOP) && (byte_idx != BYTE_LAST);

   // Control path: state, counters and the registered line.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         done     <= 1'b0;
         tx_out   <= 1'b1;
      end else begin
         done <= 1'b0;
         if (state != IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               byte_idx <= '0;
               tx_out   <= 1'b1;
               if (send) begin
                  tx_out <= 1'b0;
                  state  <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx_out  <= tx_byte[0];
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     tx_out <= 1'b1;
                     state  <= STOP;
                  end else begin
                     tx_out  <= tx_byte[0];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (byte_idx == BYTE_LAST) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     tx_out   <= 1'b0;
                     state    <= START;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data path: tx_byte always holds the next bit to drive in its LSB.
   always_ff @(posedge clk50) begin
      if (load_pkt) begin
         tx_byte   <= packet[PKT_W-1 -: 8];
         shift_buf <= packet << 8;
      end else if (load_byte) begin
         tx_byte   <= shift_buf[PKT_W-1 -: 8];
         shift_buf <= shift_buf << 8;
      end else if (shift_bit) begin
         tx_byte   <= {1'b0, tx_byte[7:1]};
      end
   end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx at 4 clocks per bit, with a simple UART
// receiver model on tx_out for the loopback scenario.
module tb_uart_packet_tx;

   localparam int CPB   = 4;
   localparam int NB    = 5;
   localparam int FRAME = NB * 10 * CPB;

   logic        clk50 = 1'b0;
   logic        rst_n;
   logic [39:0] packet;
   logic        send;
   logic        ready;
   logic        done;
   logic        tx_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic line [0:FRAME];

   // receiver model state
   logic        rx_en = 1'b0;
   int          rx_cnt = 0;
   logic [39:0] rx_pkt = '0;
   logic [7:0]  rx_b;
   logic        rx_ok;
   logic        data_received = 1'b0;

   uart_packet_tx #(
      .CLKS_PER_BIT(CPB),
      .NUM_BYTES   (NB)
   ) dut (
      .clk50 (clk50),
      .rst_n (rst_n),
      .packet(packet),
      .send  (send),
      .ready (ready),
      .done  (done),
      .tx_out(tx_out)
   );

   always #5 clk50 = ~clk50;

   // Mid-bit sampling receiver; assembles NB bytes MSB-byte first.
   always begin
      @(negedge clk50);
      if (rx_en && tx_out === 1'b0 && !data_received) begin
         repeat (CPB / 2) @(negedge clk50);
         rx_ok = (tx_out === 1'b0);
         for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk50);
            rx_b[j] = tx_out;
         end
         repeat (CPB) @(negedge clk50);
         if (tx_out !== 1'b1) rx_ok = 1'b0;
         if (rx_ok) begin
            rx_pkt = {rx_pkt[31:0], rx_b};
            rx_cnt++;
            if (rx_cnt == NB) data_received = 1'b1;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Caller raises send on a negedge; this records FRAME+1 line samples, index 0
   // being the cycle after the accept edge, and decodes the 8N1 bytes.
   task automatic run_frame(input logic hold, input logic disturb,
                            output logic [39:0] got, output int done_at,
                            output int n_done, output int ferr, output int rdy_err);
      got = '0; done_at = -1; n_done = 0; ferr = 0; rdy_err = 0;
      for (int k = 0; k <= FRAME; k++) begin
         @(negedge clk50);
         if (!hold) send = 1'b0;
         if (disturb && k == 50) begin
            packet = 40'hA5_5A5A_A5A5;
            send   = 1'b1;
         end
         line[k] = tx_out;
         if (done === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = k;
         end
         if (k < FRAME && ready !== 1'b0) rdy_err++;
      end
      for (int b = 0; b < NB; b++) begin
         for (int j = 0; j < 10; j++) begin
            int base;
            base = b * 10 * CPB + j * CPB;
            for (int c = 1; c < CPB; c++)
               if (line[base + c] !== line[base]) ferr++;
            if (j == 0) begin
               if (line[base] !== 1'b0) ferr++;
            end else if (j == 9) begin
               if (line[base] !== 1'b1) ferr++;
            end else begin
               got[31 - 8 * b + j] = line[base];
            end
         end
      end
   endtask

   task automatic test_reset();
      int bad_tx, bad_rdy, bad_done;
      bad_tx = 0; bad_rdy = 0; bad_done = 0;
      rst_n = 1'b0; send = 1'b0; packet = '0;
      repeat (3) @(negedge clk50);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk50);
         if (tx_out !== 1'b1) bad_tx++;
         if (ready !== 1'b1) bad_rdy++;
         if (done !== 1'b0) bad_done++;
      end
      n_cmp++; if (bad_tx != 0) begin n_bad++; $display("FAIL reset_tx_idle: %0d cycles not high, required 0", bad_tx); end
      n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL reset_ready: %0d cycles not ready, required 0", bad_rdy); end
      n_cmp++; if (bad_done != 0) begin n_bad++; $display("FAIL reset_done: %0d cycles with done, required 0", bad_done); end
   endtask

   task automatic test_single_packet();
      logic [39:0] got;
      logic [9:0]  wf;
      int done_at, n_done, ferr, rdy_err, wf_err;
      wf = 10'b10_0000_0010;
      wf_err = 0;
      @(negedge clk50);
      packet = 40'h01_2031_0040;
      send   = 1'b1;
      run_frame(1'b0, 1'b0, got, done_at, n_done, ferr, rdy_err);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_in_done: got %b required 1", ready); end
      for (int j = 0; j < 10; j++)
         for (int c = 0; c < CPB; c++)
            if (line[j * CPB + c] !== wf[j]) wf_err++;
      n_cmp++; if (wf_err != 0) begin n_bad++; $display("FAIL single_byte0_waveform: %0d wrong samples, required 0", wf_err); end
      n_cmp++; if (got !== 40'h01_2031_0040) begin n_bad++; $display("FAIL single_bytes: got %h required 0120310040", got); end
      n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL single_framing: %0d errors, required 0", ferr); end
      n_cmp++; if (done_at != FRAME) begin n_bad++; $display("FAIL single_done_time: got %0d required %0d", done_at, FRAME); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL single_done_count: got %0d required 1", n_done); end
      n_cmp++; if (rdy_err != 0) begin n_bad++; $display("FAIL single_busy_ready: %0d cycles ready, required 0", rdy_err); end
   endtask

   task automatic test_busy_ignore();
      logic [39:0] got;
      int done_at, n_done, ferr, rdy_err, idle_bad;
      idle_bad = 0;
      @(negedge clk50);
      packet = 40'h3C_1234_5678;
      send   = 1'b1;
      run_frame(1'b0, 1'b1, got, done_at, n_done, ferr, rdy_err);
      n_cmp++; if (got !== 40'h3C_1234_5678) begin n_bad++; $display("FAIL busy_bytes: got %h required 3c12345678", got); end
      n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL busy_framing: %0d errors, required 0", ferr); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL busy_done_count: got %0d required 1", n_done); end
      for (int k = 0; k < 60; k++) begin
         @(negedge clk50);
         if (tx_out !== 1'b1 || ready !== 1'b1 || done !== 1'b0) idle_bad++;
      end
      n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL busy_no_second_frame: %0d active cycles, required 0", idle_bad); end
   endtask

   task automatic test_back_to_back();
      logic [39:0] got;
      int done_at, n_done, ferr, rdy_err;
      @(negedge clk50);
      packet = 40'h5A_0F0F_F0F0;
      send   = 1'b1;
      run_frame(1'b1, 1'b0, got, done_at, n_done, ferr, rdy_err);
      n_cmp++; if (got !== 40'h5A_0F0F_F0F0) begin n_bad++; $display("FAIL b2b_first_bytes: got %h required 5a0f0ff0f0", got); end
      n_cmp++; if (done_at != FRAME) begin n_bad++; $display("FAIL b2b_first_done_time: got %0d required %0d", done_at, FRAME); end
      n_cmp++; if (rdy_err != 0) begin n_bad++; $display("FAIL b2b_held_send_busy: %0d cycles ready, required 0", rdy_err); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_in_done: got %b required 1", ready); end
      packet = 40'hC3_A5A5_0001;
      run_frame(1'b0, 1'b0, got, done_at, n_done, ferr, rdy_err);
      n_cmp++; if (line[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_no_gap: got %b required 0", line[0]); end
      n_cmp++; if (got !== 40'hC3_A5A5_0001) begin n_bad++; $display("FAIL b2b_second_bytes: got %h required c3a5a50001", got); end
      n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL b2b_second_framing: %0d errors, required 0", ferr); end
      n_cmp++; if (done_at != FRAME) begin n_bad++; $display("FAIL b2b_second_done_time: got %0d required %0d", done_at, FRAME); end
   endtask

   task automatic test_reset_mid_frame();
      logic [39:0] got;
      int done_at, n_done, ferr, rdy_err, late_done, idle_bad;
      late_done = 0; idle_bad = 0;
      @(negedge clk50);
      packet = 40'h11_2233_4455;
      send   = 1'b1;
      @(negedge clk50);
      send = 1'b0;
      repeat (89) @(negedge clk50);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (tx_out !== 1'b1) begin n_bad++; $display("FAIL midreset_tx_async: got %b required 1", tx_out); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b required 1", ready); end
      repeat (3) begin
         @(negedge clk50);
         if (done !== 1'b0) late_done++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk50);
         if (done !== 1'b0) late_done++;
         if (tx_out !== 1'b1) idle_bad++;
      end
      n_cmp++; if (late_done != 0) begin n_bad++; $display("FAIL midreset_no_done: %0d done cycles, required 0", late_done); end
      n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL midreset_line_idle: %0d low cycles, required 0", idle_bad); end
      packet = 40'h96_7E81_0FF0;
      send   = 1'b1;
      run_frame(1'b0, 1'b0, got, done_at, n_done, ferr, rdy_err);
      n_cmp++; if (got !== 40'h96_7E81_0FF0) begin n_bad++; $display("FAIL midreset_clean_bytes: got %h required 967e810ff0", got); end
      n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL midreset_clean_framing: %0d errors, required 0", ferr); end
      n_cmp++; if (done_at != FRAME) begin n_bad++; $display("FAIL midreset_clean_done_time: got %0d required %0d", done_at, FRAME); end
   endtask

   task automatic test_loopback();
      logic [39:0] got;
      int done_at, n_done, ferr, rdy_err;
      @(negedge clk50);
      rx_cnt = 0;
      data_received = 1'b0;
      rx_en = 1'b1;
      packet = 40'h01_2031_BEEF;
      send   = 1'b1;
      run_frame(1'b0, 1'b0, got, done_at, n_done, ferr, rdy_err);
      for (int k = 0; k < 20 && !data_received; k++) @(negedge clk50);
      rx_en = 1'b0;
      n_cmp++; if (data_received !== 1'b1) begin n_bad++; $display("FAIL loop_data_received: got %b required 1 (bytes seen %0d)", data_received, rx_cnt); end
      n_cmp++; if (rx_pkt[39:32] !== 8'h01) begin n_bad++; $display("FAIL loop_element_id: got %h required 01", rx_pkt[39:32]); end
      n_cmp++; if (rx_pkt[31:16] !== 16'h2031) begin n_bad++; $display("FAIL loop_x_pos: got %h required 2031", rx_pkt[31:16]); end
   endtask

   initial begin
      rst_n  = 1'b0;
      send   = 1'b0;
      packet = '0;
      test_reset();
      test_single_packet();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_frame();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
